// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the Nios debug JTAG host.
package nios_dbg_pkg;

  localparam int DEFAULT_DR_W = 38;

  localparam logic [1:0] IR_OCIMEM   = 2'd0;
  localparam logic [1:0] IR_TRACE    = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACEMEM = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } dbg_state_e;

endpackage

// File: rtl/nios_dbg_tck_gen.sv
// Scan clock generator: one tck period is 2*TCK_DIV clk cycles, low half first.
// rise_tick marks the clk cycle whose closing edge raises tck, fall_tick the period's last cycle.
module nios_dbg_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH = CNT_W'(TCK_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (cnt == LAST) cnt_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt_next;
      tck <= (cnt_next >= HIGH);
    end
  end

  assign rise_tick = en && (cnt == HIGH - CNT_W'(1));
  assign fall_tick = en && (cnt == LAST);

endmodule

// File: rtl/nios_dbg_jtag_host.sv
// Virtual-JTAG scan host: accepts an IR/DR command, walks UIR-CDR-SDR-UDR-RTI on a
// divided tck, shifts DR LSB first and returns the captured tdo bits as a response.
module nios_dbg_jtag_host
  import nios_dbg_pkg::*;
#(
  parameter int DR_W    = DEFAULT_DR_W,
  parameter int IR_W    = 2,
  parameter int TCK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir,
  output logic            tck,
  output logic            tdi,
  input  logic            tdo,
  output logic [IR_W-1:0] ir_in,
  input  logic [IR_W-1:0] ir_out,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            jtag_state_rti,
  output logic            busy
);

  localparam int CNT_W = (DR_W > 2) ? $clog2(DR_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DR_W - 1);

  dbg_state_e      state;
  logic [DR_W-1:0] shift;
  logic [CNT_W-1:0] bit_cnt;
  logic            gen_en;
  logic            rise_tick;
  logic            fall_tick;

  assign gen_en = (state != ST_IDLE) && (state != ST_RESP);

  nios_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (gen_en),
    .tck       (tck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      ir_in          <= '0;
      rsp_ir         <= '0;
      rsp_dr         <= '0;
      rsp_valid      <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_UIR;
            ir_in     <= cmd_ir;
            shift     <= cmd_dr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            vs_uir    <= 1'b1;
          end
        end
        ST_UIR: begin
          if (fall_tick) begin
            state  <= ST_CDR;
            rsp_ir <= ir_out;
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
          end
        end
        ST_CDR: begin
          if (fall_tick) begin
            state   <= ST_SDR;
            bit_cnt <= '0;
            tdi     <= shift[0];
            vs_cdr  <= 1'b0;
            vs_sdr  <= 1'b1;
          end
        end
        ST_SDR: begin
          // The slave shifts on this same tck rise, so tdo still holds its current bit.
          if (rise_tick) shift <= {tdo, shift[DR_W-1:1]};
          if (fall_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= ST_UDR;
              bit_cnt <= '0;
              tdi     <= 1'b0;
              vs_sdr  <= 1'b0;
              vs_udr  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tdi     <= shift[0];
            end
          end
        end
        ST_UDR: begin
          if (fall_tick) begin
            state          <= ST_RTI;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
          end
        end
        ST_RTI: begin
          if (fall_tick) begin
            state          <= ST_RESP;
            jtag_state_rti <= 1'b0;
            rsp_dr         <= shift;
            rsp_valid      <= 1'b1;
          end
        end
        ST_RESP: begin
          // cmd_ready rises only after this handshake, so a waiting command lands one cycle later.
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios_dbg_jtag_host.md
NIOS_DBG_JTAG_HOST -- requirements
Module: nios_dbg_jtag_host

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all ports below are synchronous to clk.
REQ-002 Parameter DR_W, default 38, sets the data-register scan length in bits.
REQ-003 Parameter IR_W, default 2, sets the virtual instruction width.
REQ-004 Parameter TCK_DIV, default 2, minimum 1, sets the number of clk cycles per tck half-period.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_ir  in  IR_W  virtual IR value for the command.
REQ-009 cmd_dr  in  DR_W  data to shift in, sent LSB first.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_dr  out  DR_W  data captured from tdo.
REQ-012 tck / tdi  out / out  1 / 1  generated scan clock and serial data.
REQ-013 tdo  in  1  serial data returned by the debug slave.
REQ-014 ir_in  out  IR_W  instruction presented to the slave.
REQ-015 ir_out  in  IR_W  slave status; registered into rsp_ir during the UIR state.
REQ-016 vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual-state strobes.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 A tck period SHALL be 2*TCK_DIV clk cycles: tck is low for the first TCK_DIV cycles and high for the last TCK_DIV cycles.
REQ-019 tck SHALL be held low in IDLE and RESP.
REQ-020 State changes, tdi updates, and strobe updates SHALL occur only at tck period boundaries (falling edges).
REQ-021 FSM sequence: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
- UIR, CDR, UDR, and RTI each last exactly 1 tck period.
- SDR lasts exactly DR_W tck periods.
REQ-022 Strobes: exactly one of vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti SHALL be high in its matching state, and all SHALL be low in IDLE and RESP.
REQ-023 cmd_ready SHALL be high only in IDLE; on cmd_valid&&cmd_ready the block latches cmd_ir into ir_in and cmd_dr into the shift register, and enters UIR on the next clk.
REQ-024 ir_in SHALL hold the latched value from UIR through RESP.
REQ-025 In SDR, tdi SHALL equal shift[0] for the whole period.
REQ-026 In SDR, tdo SHALL be sampled on the clk cycle in which tck rises, then shift <= {tdo_sample, shift[DR_W-1:1]}.
REQ-027 After DR_W shifts, rsp_dr SHALL equal the slave's shift register as captured in CDR.
REQ-028 A shift-bit counter SHALL count 0..DR_W-1 and SHALL NOT wrap; SDR exits when the counter reaches DR_W-1 at a period boundary.
REQ-029 rsp_valid SHALL assert exactly (DR_W+4)*2*TCK_DIV clk cycles after the accept cycle (168 with defaults).
REQ-030 rsp_valid SHALL hold, with rsp_dr stable, until rsp_ready; on the handshake cycle the FSM returns to IDLE.
REQ-031 Simultaneous rsp handshake and cmd_valid: the command SHALL NOT be accepted in that cycle; the earliest accept is the next cycle.
REQ-032 tdi SHALL be 0 outside SDR.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE.
REQ-034 Reset values: tck=0, tdi=0, all strobes=0, cmd_ready=1 on the cycle after reset deasserts, rsp_valid=0, busy=0, ir_in=0, rsp_dr=0, counters=0.
REQ-035 Reset mid-scan SHALL abort immediately, discard partial data, and emit no UDR strobe.

Structure
REQ-036 Shared package nios_dbg_pkg SHALL hold:
- the FSM state enum;
- the IR code constants IR_OCIMEM=0, IR_TRACE=1, IR_BREAK=2, IR_TRACEMEM=3;
- the default DR_W.
REQ-037 A single sub-module, nios_dbg_tck_gen, SHALL produce tck, a rise-tick, and a fall-tick from clk, enabled by the FSM.

Verification
REQ-038 Bench uses a behavioural slave model (sr loads 38'h2A_5A5A_5A5A on vs_cdr; shifts sr={tdi,sr[37:1]} on tck rise; tdo=sr[0]). Directed scenarios:
- Single command: cmd_ir=2, cmd_dr=38'h15_A5A5_A5A5 -> rsp_dr=38'h2A_5A5A_5A5A; model sr=38'h15_A5A5_A5A5 at vs_udr; rsp_valid at accept+168.
- Backpressure: rsp_ready low for 50 cycles -> rsp_valid and rsp_dr stable, cmd_ready=0 throughout, tck low.
- Back-to-back commands with cmd_valid held -> second accept exactly 1 cycle after rsp handshake; strobe order UIR,CDR,SDR x38,UDR,RTI repeated.
- Reset asserted at shift bit 17 -> next cycle: all strobes 0, tck 0, cmd_ready 1 after release, no vs_udr pulse.
- TCK_DIV=1 and TCK_DIV=5 -> tck period 2 and 10 clk cycles, latency 84 and 420 cycles, data correct.
- cmd_dr all-ones, model capture all-zeros -> rsp_dr=0; tdi=0 outside SDR.
